cgra_cmem_loader: RTL and testbench
===================================

Name: cgra_cmem_loader

Overview:
- Bitstream loader upstream of the CGRA context-memory slave port.
- Copies a block of 32-bit configuration words from system memory into the CGRA context memory without CPU involvement.
- Reads over an OBI-style master port, buffers the words in a small FIFO, and writes them in order through the cm_* request/grant interface.
- Software sets it up and starts it via a register front-end. Completion is signalled with a pulse that the front-end turns into an interrupt.

Parameters:
- ADDR_WIDTH, 32, byte-address width of both the read and the context-memory ports
- DATA_WIDTH, 32, word width; fixed at 32 (byte enable is 4 bits)
- LEN_WIDTH, 16, width of the transfer length in words
- FIFO_DEPTH, 4, read-data buffer depth in words; power of two, at least 2

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle start strobe
- abort_i  in  1  one-cycle abort strobe
- src_addr_i  in  ADDR_WIDTH  source byte address, word aligned
- dst_addr_i  in  ADDR_WIDTH  context-memory byte address, word aligned
- len_i  in  LEN_WIDTH  number of words to copy
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse
- aborted_o  out  1  last transfer ended by abort; sticky until next start
- words_done_o  out  LEN_WIDTH  words written to the context memory in the current/last transfer
- rd_req_o  out  1  read request
- rd_addr_o  out  ADDR_WIDTH  read address
- rd_gnt_i  in  1  read grant
- rd_rdata_i  in  DATA_WIDTH  read data
- rd_rvalid_i  in  1  read data valid (responses return in order)
- cm_req_o  out  1  context-memory write request
- cm_add_o  out  ADDR_WIDTH  context-memory address
- cm_we_o  out  1  write enable; constant 1
- cm_be_o  out  4  byte enable; constant 4'hF
- cm_wdata_o  out  DATA_WIDTH  write data
- cm_gnt_i  in  1  context-memory grant; write is complete on grant

Behaviour:
- Reset values:
  - busy_o, done_o, aborted_o, rd_req_o, cm_req_o = 0.
  - words_done_o, rd_addr_o, cm_add_o, cm_wdata_o = 0.
  - cm_we_o = 1, cm_be_o = 4'hF.
  - FSM in IDLE, FIFO empty, all counters 0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE + start_i with len_i != 0: latch src, dst and len; clear counters and aborted_o; go to RUN; busy_o=1 from the next cycle.
  - IDLE + start_i with len_i == 0: done_o pulses the next cycle; no bus traffic; aborted_o cleared.
  - start_i while busy_o=1: ignored.
  - RUN -> IDLE: when written == len and the cm grant is accepted. done_o pulses that next cycle; busy_o drops in the same cycle.
  - RUN + abort_i -> DRAIN.
  - DRAIN -> IDLE: when outstanding reads == 0 and no request is pending without grant. done_o pulses and aborted_o=1.
  - abort_i in IDLE: ignored.
- Read issue:
  - rd_req_o=1 when in RUN, issued < len, and (outstanding + fifo_count) < FIFO_DEPTH. This credit scheme guarantees the FIFO can never overflow.
  - rd_addr_o = src + 4*issued, modulo 2^ADDR_WIDTH.
  - Once asserted, rd_req_o and rd_addr_o stay stable until rd_gnt_i, including in DRAIN.
  - On gnt: issued++ and outstanding++.
- Read response:
  - rd_rvalid_i decrements outstanding.
  - In RUN, rdata is pushed to the FIFO; in DRAIN it is discarded.
  - Grant and rvalid in the same cycle leave outstanding unchanged.
- Write:
  - cm_req_o = FIFO non-empty (RUN) or a held pending request (DRAIN).
  - cm_add_o = dst + 4*written; cm_wdata_o = FIFO head.
  - Request and data stay stable until cm_gnt_i.
  - On gnt: pop, written++, words_done_o++.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Abort:
  - Any request already asserted completes its handshake.
  - No new requests are issued.
  - The FIFO is flushed once the pending cm request is granted.
  - words_done_o reports the words actually written.
- Zero-latency paths: cm_gnt_i combinational with cm_req_o, and rd_rvalid_i in the cycle after rd_gnt_i, must sustain 1 word/cycle throughput.
- Reset mid-operation: everything returns to reset values immediately; no done_o pulse.

Test Plan:
1. src=0x1000, dst=0x0, len=3, memory returns 0xA0,0xA1,0xA2, grants always high -> cm writes 0xA0@0x0, 0xA1@0x4, 0xA2@0x8; done_o one pulse; words_done_o=3; aborted_o=0.
2. len=8, cm_gnt_i held low for 20 cycles -> exactly FIFO_DEPTH=4 reads granted and no more; cm_req_o and address stable throughout; after release, all 8 words are written in order.
3. len=16, abort_i after 5 words written, 2 reads outstanding -> no new rd_req; 2 rvalids are absorbed; done_o pulses with aborted_o=1 and words_done_o=5 or 6 (6 only if a cm request was pending).
4. start_i with len=0 -> done_o in the next cycle; rd_req_o and cm_req_o never assert.
5. src=0xFFFFFFF8, len=4 -> read addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
6. rst_ni low mid-transfer (len=10, 4 written) -> all outputs at reset values; a new start with len=2 completes normally with words_done_o=2.

Source files
------------

// File: rtl/cgra_cmem_loader.sv
// Context-memory bitstream loader: copies len_i words from system memory into the
// CGRA context memory through a small read-data FIFO, paced by a read-credit limit.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | issuing reads, buffering responses, writing words to the context memory
// DRAIN | aborted; finishing already-asserted handshakes and absorbing late read data
module cgra_cmem_loader #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [ADDR_WIDTH-1:0] src_addr_i,
   input  logic [ADDR_WIDTH-1:0] dst_addr_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  aborted_o,
   output logic [LEN_WIDTH-1:0]  words_done_o,
   output logic                  rd_req_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   input  logic                  rd_gnt_i,
   input  logic [DATA_WIDTH-1:0] rd_rdata_i,
   input  logic                  rd_rvalid_i,
   output logic                  cm_req_o,
   output logic [ADDR_WIDTH-1:0] cm_add_o,
   output logic                  cm_we_o,
   output logic [3:0]            cm_be_o,
   output logic [DATA_WIDTH-1:0] cm_wdata_o,
   input  logic                  cm_gnt_i
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SUM_W = CNT_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0] src_q, dst_q;
   logic [LEN_WIDTH-1:0]  len_q, issued_q, written_q, written_inc;
   logic [CNT_W-1:0]      outstanding_q, count_q;
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
   logic [SUM_W-1:0]      in_flight;

   logic rd_hold_q, cm_hold_q, done_q, aborted_q;
   logic rd_req, cm_req, rd_fire, cm_fire, push, pop;
   logic start_ok, zero_start, last_write, drain_exit, rd_credit;

   assign written_inc = written_q + LEN_WIDTH'(1);
   // outstanding reads plus buffered words may never exceed the FIFO depth
   assign in_flight   = SUM_W'(outstanding_q) + SUM_W'(count_q);
   assign rd_credit   = in_flight < SUM_W'(FIFO_DEPTH);

   always_comb begin
      state_d    = state_q;
      rd_req     = 1'b0;
      cm_req     = 1'b0;
      start_ok   = 1'b0;
      zero_start = 1'b0;
      last_write = 1'b0;
      drain_exit = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (len_i != '0) begin
                  start_ok = 1'b1;
                  state_d  = RUN;
               end else begin
                  zero_start = 1'b1;
               end
            end
         end
         RUN: begin
            rd_req     = (issued_q < len_q) && rd_credit;
            cm_req     = (count_q != '0);
            last_write = cm_req && cm_gnt_i && (written_inc == len_q);
            if (last_write) begin
               state_d = IDLE;
            end else if (abort_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // only requests left hanging at abort time stay on the bus
            rd_req = rd_hold_q;
            cm_req = cm_hold_q;
            if ((outstanding_q == '0) && !rd_hold_q && !cm_hold_q) begin
               drain_exit = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rd_fire = rd_req && rd_gnt_i;
   assign cm_fire = cm_req && cm_gnt_i;
   assign push    = rd_rvalid_i && (state_q == RUN);
   assign pop     = cm_fire;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         rd_hold_q <= 1'b0;
         cm_hold_q <= 1'b0;
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= '0;
      end else begin
         state_q   <= state_d;
         done_q    <= zero_start || last_write || drain_exit;
         rd_hold_q <= rd_req && !rd_gnt_i;
         cm_hold_q <= cm_req && !cm_gnt_i;
         if (start_ok) begin
            src_q <= src_addr_i;
            dst_q <= dst_addr_i;
            len_q <= len_i;
         end
         if (start_ok || zero_start) begin
            aborted_q <= 1'b0;
         end else if (drain_exit) begin
            aborted_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         issued_q      <= '0;
         written_q     <= '0;
         outstanding_q <= '0;
      end else begin
         if (start_ok || zero_start) begin
            issued_q  <= '0;
            written_q <= '0;
         end else begin
            if (rd_fire) issued_q <= issued_q + LEN_WIDTH'(1);
            if (cm_fire) written_q <= written_inc;
         end
         if (rd_fire && !rd_rvalid_i) begin
            outstanding_q <= outstanding_q + CNT_W'(1);
         end else if (!rd_fire && rd_rvalid_i && (outstanding_q != '0)) begin
            outstanding_q <= outstanding_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      end else if (drain_exit) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= rd_rdata_i;
            wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push && !pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   assign busy_o       = (state_q != IDLE);
   assign done_o       = done_q;
   assign aborted_o    = aborted_q;
   assign words_done_o = written_q;
   assign rd_req_o     = rd_req;
   assign rd_addr_o    = src_q + (ADDR_WIDTH'(issued_q) << 2);
   assign cm_req_o     = cm_req;
   assign cm_add_o     = dst_q + (ADDR_WIDTH'(written_q) << 2);
   assign cm_we_o      = 1'b1;
   assign cm_be_o      = 4'hF;
   assign cm_wdata_o   = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_cgra_cmem_loader.sv
// Bench for cgra_cmem_loader: randomized read/write slaves with a word-index memory
// model; every transfer is compared with the expected address/data sequence.
module tb_cgra_cmem_loader;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 16;
   localparam int FD = 4;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [AW-1:0] src_addr_i = '0;
   logic [AW-1:0] dst_addr_i = '0;
   logic [LW-1:0] len_i = '0;
   logic          busy_o, done_o, aborted_o;
   logic [LW-1:0] words_done_o;
   logic          rd_req_o;
   logic [AW-1:0] rd_addr_o;
   logic          rd_gnt_i;
   logic [DW-1:0] rd_rdata_i;
   logic          rd_rvalid_i;
   logic          cm_req_o;
   logic [AW-1:0] cm_add_o;
   logic          cm_we_o;
   logic [3:0]    cm_be_o;
   logic [DW-1:0] cm_wdata_o;
   logic          cm_gnt_i;

   cgra_cmem_loader #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .LEN_WIDTH  (LW),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .src_addr_i   (src_addr_i),
      .dst_addr_i   (dst_addr_i),
      .len_i        (len_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .aborted_o    (aborted_o),
      .words_done_o (words_done_o),
      .rd_req_o     (rd_req_o),
      .rd_addr_o    (rd_addr_o),
      .rd_gnt_i     (rd_gnt_i),
      .rd_rdata_i   (rd_rdata_i),
      .rd_rvalid_i  (rd_rvalid_i),
      .cm_req_o     (cm_req_o),
      .cm_add_o     (cm_add_o),
      .cm_we_o      (cm_we_o),
      .cm_be_o      (cm_be_o),
      .cm_wdata_o   (cm_wdata_o),
      .cm_gnt_i     (cm_gnt_i)
   );

   always #5 clk_i = ~clk_i;

   int n_tot = 0;
   int n_pass = 0;
   int n_fail = 0;

   int unsigned rg_pct = 100;
   int unsigned rv_pct = 100;
   int unsigned cg_pct = 100;
   bit          cm_stall = 1'b0;
   logic [31:0] mem_org = '0;
   logic [31:0] mem_base = '0;

   logic [31:0] rd_log[$];
   logic [31:0] cm_add_log[$];
   logic [31:0] cm_dat_log[$];
   logic [31:0] rsp_q[$];
   int          done_cnt = 0;
   int          rd_req_seen = 0;
   int          cm_req_seen = 0;

   bit          rd_wait = 1'b0;
   bit          cm_wait = 1'b0;
   logic [31:0] rd_wait_addr, cm_wait_add, cm_wait_dat;

   // memory holds word index (relative to the transfer source) offset by mem_base
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return mem_base + ((a - mem_org) >> 2);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // bus slaves: decide responses on the falling edge, DUT samples them on the rising edge
   initial begin
      rd_gnt_i    = 1'b0;
      rd_rvalid_i = 1'b0;
      rd_rdata_i  = '0;
      cm_gnt_i    = 1'b0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            rsp_q.delete();
            rd_wait     = 1'b0;
            cm_wait     = 1'b0;
            rd_gnt_i    = 1'b0;
            rd_rvalid_i = 1'b0;
            cm_gnt_i    = 1'b0;
         end else begin
            if (done_o) done_cnt++;
            if (rd_req_o) rd_req_seen++;
            if (cm_req_o) cm_req_seen++;
            if (rd_wait) begin
               chk("rd_req_held", 32'(rd_req_o), 32'd1);
               chk("rd_addr_held", rd_addr_o, rd_wait_addr);
            end
            if (cm_wait) begin
               chk("cm_req_held", 32'(cm_req_o), 32'd1);
               chk("cm_add_held", cm_add_o, cm_wait_add);
               chk("cm_wdata_held", cm_wdata_o, cm_wait_dat);
            end
            rd_rvalid_i = 1'b0;
            if (rsp_q.size() != 0 && $urandom_range(99) < rv_pct) begin
               rd_rvalid_i = 1'b1;
               rd_rdata_i  = rsp_q.pop_front();
            end
            rd_gnt_i = rd_req_o && ($urandom_range(99) < rg_pct);
            if (rd_gnt_i) begin
               rd_log.push_back(rd_addr_o);
               rsp_q.push_back(mem_word(rd_addr_o));
            end
            rd_wait      = rd_req_o && !rd_gnt_i;
            rd_wait_addr = rd_addr_o;
            cm_gnt_i = cm_req_o && !cm_stall && ($urandom_range(99) < cg_pct);
            if (cm_gnt_i) begin
               cm_add_log.push_back(cm_add_o);
               cm_dat_log.push_back(cm_wdata_o);
            end
            cm_wait     = cm_req_o && !cm_gnt_i;
            cm_wait_add = cm_add_o;
            cm_wait_dat = cm_wdata_o;
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
      chk({tag, "_done"}, 32'(done_o), 32'd0);
      chk({tag, "_aborted"}, 32'(aborted_o), 32'd0);
      chk({tag, "_rd_req"}, 32'(rd_req_o), 32'd0);
      chk({tag, "_cm_req"}, 32'(cm_req_o), 32'd0);
      chk({tag, "_words_done"}, 32'(words_done_o), 32'd0);
      chk({tag, "_rd_addr"}, rd_addr_o, 32'd0);
      chk({tag, "_cm_add"}, cm_add_o, 32'd0);
      chk({tag, "_cm_wdata"}, cm_wdata_o, 32'd0);
      chk({tag, "_cm_we"}, 32'(cm_we_o), 32'd1);
      chk({tag, "_cm_be"}, 32'(cm_be_o), 32'hF);
   endtask

   task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
      rd_log.delete();
      cm_add_log.delete();
      cm_dat_log.delete();
      done_cnt    = 0;
      rd_req_seen = 0;
      cm_req_seen = 0;
      mem_org     = s;
      src_addr_i  = s;
      dst_addr_i  = d;
      len_i       = n;
      start_i     = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      chk("busy_after_start", 32'(busy_o), (n != 0) ? 32'd1 : 32'd0);
   endtask

   task automatic wait_done(input int limit, output int cyc);
      cyc = 0;
      while (done_o !== 1'b1 && cyc < limit) begin
         @(negedge clk_i);
         cyc++;
      end
      chk("done_within_bound", 32'(done_o), 32'd1);
   endtask

   task automatic verify_full(input logic [31:0] s, input logic [31:0] d, input int n);
      chk("words_done", 32'(words_done_o), 32'(n));
      chk("aborted_clear", 32'(aborted_o), 32'd0);
      chk("busy_at_done", 32'(busy_o), 32'd0);
      chk("cm_write_count", 32'(cm_add_log.size()), 32'(n));
      chk("rd_grant_count", 32'(rd_log.size()), 32'(n));
      for (int i = 0; i < n && i < cm_add_log.size(); i++) begin
         chk("cm_addr", cm_add_log[i], d + 32'(4 * i));
         chk("cm_data", cm_dat_log[i], mem_word(s + 32'(4 * i)));
      end
      for (int i = 0; i < n && i < rd_log.size(); i++) begin
         chk("rd_addr", rd_log[i], s + 32'(4 * i));
      end
      @(negedge clk_i);
      chk("done_one_cycle", 32'(done_o), 32'd0);
      chk("done_pulse_count", 32'(done_cnt), 32'd1);
   endtask

   initial begin
      int          cyc;
      int          seen_low;
      int          bad;
      int          wd;
      logic [31:0] s, d;
      logic [15:0] n;

      // reset state
      repeat (3) @(negedge clk_i);
      check_reset_vals("reset");
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);

      // three words, grants always high: one word per cycle after the pipeline fills
      mem_base = 32'hA0;
      kick(32'h1000, 32'h0, 16'd3);
      wait_done(200, cyc);
      chk("t1_latency", 32'(cyc), 32'd5);
      verify_full(32'h1000, 32'h0, 3);
      chk("t1_word0", (cm_dat_log.size() > 0) ? cm_dat_log[0] : 32'hDEAD, 32'hA0);

      // context memory stalled: credit stops reads at FIFO depth
      mem_base = $urandom();
      s = $urandom() & 32'hFFFF_FFFC;
      d = $urandom() & 32'h0000_FFFC;
      cm_stall = 1'b1;
      kick(s, d, 16'd8);
      repeat (10) @(negedge clk_i);
      src_addr_i = 32'h5555_0000;
      len_i      = 16'd3;
      start_i    = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (9) @(negedge clk_i);
      chk("t2_reads_capped", 32'(rd_log.size()), 32'(FD));
      chk("t2_rd_req_low", 32'(rd_req_o), 32'd0);
      chk("t2_cm_req_high", 32'(cm_req_o), 32'd1);
      chk("t2_cm_add", cm_add_o, d);
      chk("t2_no_words", 32'(words_done_o), 32'd0);
      cm_stall = 1'b0;
      wait_done(400, cyc);
      verify_full(s, d, 8);

      // read address wraps at the top of the address space
      mem_base = $urandom();
      kick(32'hFFFF_FFF8, 32'h200, 16'd4);
      wait_done(200, cyc);
      verify_full(32'hFFFF_FFF8, 32'h200, 4);
      chk("t5_wrap_addr", (rd_log.size() > 2) ? rd_log[2] : 32'hDEAD, 32'h0);

      // abort after five words with slow read responses
      rg_pct = 100; rv_pct = 40; cg_pct = 60;
      mem_base = $urandom();
      s = $urandom() & 32'hFFFF_FFFC;
      d = $urandom() & 32'h0000_FFFC;
      kick(s, d, 16'd16);
      cyc = 0;
      while (words_done_o != 16'd5 && cyc < 600) begin
         @(negedge clk_i);
         cyc++;
      end
      chk("t3_reached_5", 32'(words_done_o), 32'd5);
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      seen_low = 0;
      bad = 0;
      cyc = 0;
      while (done_o !== 1'b1 && cyc < 600) begin
         if (!rd_req_o) seen_low = 1;
         else if (seen_low != 0) bad++;
         @(negedge clk_i);
         cyc++;
      end
      chk("t3_done", 32'(done_o), 32'd1);
      chk("t3_aborted", 32'(aborted_o), 32'd1);
      chk("t3_busy_low", 32'(busy_o), 32'd0);
      chk("t3_no_new_reads", 32'(bad), 32'd0);
      chk("t3_responses_absorbed", 32'(rsp_q.size()), 32'd0);
      chk("t3_reads_bounded", 32'(rd_log.size() <= 10), 32'd1);
      wd = int'(words_done_o);
      chk("t3_words_match_bus", 32'(wd), 32'(cm_add_log.size()));
      chk("t3_words_5_or_6", 32'(wd == 5 || wd == 6), 32'd1);
      for (int i = 0; i < cm_add_log.size(); i++) begin
         chk("t3_cm_addr", cm_add_log[i], d + 32'(4 * i));
         chk("t3_cm_data", cm_dat_log[i], mem_word(s + 32'(4 * i)));
      end
      @(negedge clk_i);
      chk("t3_done_count", 32'(done_cnt), 32'd1);
      chk("t3_aborted_sticky", 32'(aborted_o), 32'd1);

      // zero-length start: immediate done, no bus traffic, aborted cleared
      rg_pct = 100; rv_pct = 100; cg_pct = 100;
      kick(32'h3000, 32'h40, 16'd0);
      chk("t4_done_next_cycle", 32'(done_o), 32'd1);
      chk("t4_aborted_cleared", 32'(aborted_o), 32'd0);
      chk("t4_words_zero", 32'(words_done_o), 32'd0);
      repeat (4) @(negedge clk_i);
      chk("t4_no_rd_req", 32'(rd_req_seen), 32'd0);
      chk("t4_no_cm_req", 32'(cm_req_seen), 32'd0);
      chk("t4_done_count", 32'(done_cnt), 32'd1);

      // reset in the middle of a transfer, then a clean restart
      mem_base = $urandom();
      kick(32'h8000, 32'h100, 16'd10);
      cyc = 0;
      while (words_done_o != 16'd4 && cyc < 200) begin
         @(negedge clk_i);
         cyc++;
      end
      chk("t6_reached_4", 32'(words_done_o), 32'd4);
      #2 rst_ni = 1'b0;
      #1 check_reset_vals("midreset");
      repeat (2) @(negedge clk_i);
      chk("t6_no_done_on_reset", 32'(done_cnt), 32'd0);
      #2 rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);
      chk("t6_idle_after_reset", 32'(busy_o), 32'd0);
      mem_base = $urandom();
      kick(32'h9000, 32'h20, 16'd2);
      wait_done(200, cyc);
      verify_full(32'h9000, 32'h20, 2);

      // randomized transfers against the word-sequence model
      for (int k = 0; k < 8; k++) begin
         rg_pct = $urandom_range(100, 30);
         rv_pct = $urandom_range(100, 30);
         cg_pct = $urandom_range(100, 30);
         mem_base = $urandom();
         s = $urandom() & 32'hFFFF_FFFC;
         d = $urandom() & 32'hFFFF_FFFC;
         n = 16'($urandom_range(20, 1));
         kick(s, d, n);
         wait_done(2000, cyc);
         verify_full(s, d, int'(n));
         repeat (2) @(negedge clk_i);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
